// File: rtl/async_fifo_wr_packer_pkg.sv
// Shared types, defaults and width helpers for the async_fifo write-side packer.
// ASYNC_FIFO_PACK_TAG_EN adds a {last_flag, lane_count-1} tag above the packed data.
package async_fifo_wr_packer_pkg;

   localparam int unsigned PACK_RATIO_DEFAULT    = 4;
   localparam int unsigned PACK_IN_WIDTH_DEFAULT = 8;

   typedef logic [PACK_IN_WIDTH_DEFAULT-1:0] pack_lane_t;

`ifdef ASYNC_FIFO_PACK_TAG_EN
   localparam bit PACK_TAG_EN = 1'b1;
`else
   localparam bit PACK_TAG_EN = 1'b0;
`endif

   // Lane-count field width; kept at least 1 so RATIO=1 still carries a field.
   function automatic int unsigned pack_cnt_w(input int unsigned ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   function automatic int unsigned pack_tag_w(input int unsigned ratio);
      return PACK_TAG_EN ? 1 + pack_cnt_w(ratio) : 32'd0;
   endfunction

endpackage

// File: rtl/async_fifo_wr_packer_if.sv
// Upstream beat stream plus FIFO write port of the packer, grouped as one bundle.
// master is the packer's view; slave is the source/FIFO side.
interface async_fifo_wr_packer_if #(
   parameter int unsigned IN_WIDTH = 8,
   parameter int unsigned W_DW     = 32
);

   logic                in_valid;
   logic                in_ready;
   logic [IN_WIDTH-1:0] in_data;
   logic                in_last;
   logic                w_valid;
   logic                w_ready;
   logic [W_DW-1:0]     w_data;

   modport master (
      input  in_valid, in_data, in_last, w_ready,
      output in_ready, w_valid, w_data
   );

   modport slave (
      output in_valid, in_data, in_last, w_ready,
      input  in_ready, w_valid, w_data
   );

endinterface

// File: rtl/async_fifo_wr_packer.sv
// Packs RATIO narrow beats (or fewer, closed by in_last) into one registered FIFO word.
// Optional tag via ASYNC_FIFO_PACK_TAG_EN: w_data = {last_flag, lane_count-1, data}.
module async_fifo_wr_packer
   import async_fifo_wr_packer_pkg::*;
#(
   parameter int unsigned IN_WIDTH = PACK_IN_WIDTH_DEFAULT,
   parameter int unsigned RATIO    = PACK_RATIO_DEFAULT
) (
   input logic                   wclk,
   input logic                   wrst,
   async_fifo_wr_packer_if.master bus
);

   localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
   localparam int unsigned CNT_W     = pack_cnt_w(RATIO);
   localparam int unsigned TAG_W     = pack_tag_w(RATIO);
   localparam int unsigned W_DW      = OUT_WIDTH + TAG_W;

   logic                 w_valid_q;
   logic [W_DW-1:0]      w_data_q;
   logic [CNT_W-1:0]     lane_q;
   logic [OUT_WIDTH-1:0] acc_q;

   logic                 in_ready;
   logic                 accept;
   logic                 complete;
   logic [OUT_WIDTH-1:0] acc_merged;
   logic [W_DW-1:0]      word;

   // Only the output register's state and w_ready gate the source.
   assign in_ready = ~wrst & (~w_valid_q | bus.w_ready);
   assign accept   = bus.in_valid & in_ready;
   assign complete = accept & ((lane_q == CNT_W'(RATIO - 1)) | bus.in_last);

   // Lanes above lane_q are still zero from the last clear, which zero-pads short words.
   always_comb begin
      acc_merged = acc_q;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (lane_q == CNT_W'(i)) begin
            acc_merged[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
         end
      end
   end

   always_comb begin
      word = '0;
`ifdef ASYNC_FIFO_PACK_TAG_EN
      word = {bus.in_last, lane_q, acc_merged};
`else
      word = acc_merged;
`endif
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         w_valid_q <= 1'b0;
         w_data_q  <= '0;
         lane_q    <= '0;
         acc_q     <= '0;
      end else if (complete) begin
         // A completing beat can only be taken when the register is free or draining.
         w_valid_q <= 1'b1;
         w_data_q  <= word;
         lane_q    <= '0;
         acc_q     <= '0;
      end else begin
         if (accept) begin
            acc_q  <= acc_merged;
            lane_q <= lane_q + CNT_W'(1);
         end
         if (w_valid_q && bus.w_ready) begin
            w_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.w_valid  = w_valid_q;
   assign bus.w_data   = w_data_q;

endmodule
